// File: rtl/dmem_arb_ctrl_pkg.sv
// Shared widths, size encodings and FSM state type for the data-memory arbiter/controller.
// Also holds the misalignment rule so the checker and any future user agree on it.
package dmem_arb_ctrl_pkg;

    localparam int RV32_ADDR_WIDTH = 32;
    localparam int RV32_DATA_WIDTH = 32;
    localparam int DMEM_DATA_WIDTH = 32;
    localparam int LDST_TAG_WIDTH  = 4;

    typedef enum logic [1:0] {
        MEM_SIZE_B   = 2'b00,
        MEM_SIZE_H   = 2'b01,
        MEM_SIZE_W   = 2'b10,
        MEM_SIZE_ILL = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LD_WAIT,
        S_ST_MERGE,
        S_RESP_ERR
    } arb_state_e;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (mem_size_e'(size))
            MEM_SIZE_B: is_misaligned = 1'b0;
            MEM_SIZE_H: is_misaligned = off[0];
            MEM_SIZE_W: is_misaligned = (off != 2'b00);
            default:    is_misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Combinational lane formatting: load extract/extend, sub-word store merge and
// misalignment check for the request being arbitrated.
module dmem_lane_fmt
    import dmem_arb_ctrl_pkg::*;
(
    input  logic [1:0]                 chk_off,
    input  logic [1:0]                 chk_size,
    output logic                       chk_misaligned,
    input  logic [1:0]                 off,
    input  logic [1:0]                 size,
    input  logic                       is_unsigned,
    input  logic [DMEM_DATA_WIDTH-1:0] rd_data,
    output logic [RV32_DATA_WIDTH-1:0] ld_data,
    input  logic [RV32_DATA_WIDTH-1:0] st_data,
    output logic [RV32_DATA_WIDTH-1:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        chk_misaligned = is_misaligned(chk_size, chk_off);
        byte_sel       = rd_data[{off, 3'b000} +: 8];
        half_sel       = rd_data[{off[1], 4'b0000} +: 16];

        case (mem_size_e'(size))
            MEM_SIZE_B: ld_data = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            MEM_SIZE_H: ld_data = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default:    ld_data = rd_data;
        endcase

        // Only the addressed lane changes; the rest of the old word is written back as read.
        merged = rd_data;
        case (mem_size_e'(size))
            MEM_SIZE_B: merged[{off, 3'b000} +: 8]     = st_data[7:0];
            MEM_SIZE_H: merged[{off[1], 4'b0000} +: 16] = st_data[15:0];
            default:    merged = st_data;
        endcase
    end

endmodule

// File: rtl/dmem_arb_ctrl.sv
// Load/store arbiter and controller in front of the single-port synchronous data memory.
// Loads win arbitration unless a waiting store has lost STARVE_LIMIT times in a row.
module dmem_arb_ctrl
    import dmem_arb_ctrl_pkg::*;
#(
    parameter int TAG_WIDTH    = LDST_TAG_WIDTH,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_ld_valid,
    output logic                       o_ld_ready,
    input  logic [RV32_ADDR_WIDTH-1:0] i_ld_addr,
    input  logic [1:0]                 i_ld_size,
    input  logic                       i_ld_unsigned,
    input  logic [TAG_WIDTH-1:0]       i_ld_tag,
    output logic                       o_ldr_valid,
    output logic [RV32_DATA_WIDTH-1:0] o_ldr_data,
    output logic [TAG_WIDTH-1:0]       o_ldr_tag,
    output logic                       o_ldr_misaligned,
    input  logic                       i_st_valid,
    output logic                       o_st_ready,
    input  logic [RV32_ADDR_WIDTH-1:0] i_st_addr,
    input  logic [1:0]                 i_st_size,
    input  logic [RV32_DATA_WIDTH-1:0] i_st_data,
    output logic                       o_st_done,
    output logic                       o_st_misaligned,
    output logic [RV32_ADDR_WIDTH-1:0] o_mem_addr,
    output logic                       o_mem_wr_en,
    output logic [RV32_DATA_WIDTH-1:0] o_mem_wr_data,
    input  logic [DMEM_DATA_WIDTH-1:0] i_mem_rd_data
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_e                 state_q, state_d;
    logic [CNT_W-1:0]           starve_q, starve_d;
    logic [RV32_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]                 size_q, size_d;
    logic                       uns_q, uns_d;
    logic [TAG_WIDTH-1:0]       tag_q, tag_d;
    logic [RV32_DATA_WIDTH-1:0] st_data_q, st_data_d;
    logic                       ldr_valid_q, ldr_valid_d;
    logic [RV32_DATA_WIDTH-1:0] ldr_data_q, ldr_data_d;
    logic [TAG_WIDTH-1:0]       ldr_tag_q, ldr_tag_d;
    logic                       ldr_mis_q, ldr_mis_d;
    logic                       st_done_q, st_done_d;
    logic                       st_mis_q, st_mis_d;

    logic                       starved, ld_grant, st_grant, acc_mis, wr_en;
    logic [RV32_ADDR_WIDTH-1:0] acc_addr;
    logic [1:0]                 acc_size;
    logic [RV32_ADDR_WIDTH-3:0] mem_word;
    logic [RV32_DATA_WIDTH-1:0] wr_data, fmt_ld_data, fmt_merged;

    assign starved  = (starve_q == STARVE_MAX);
    assign ld_grant = i_ld_valid && !(i_st_valid && starved);
    assign st_grant = i_st_valid && !ld_grant;
    assign acc_addr = ld_grant ? i_ld_addr : i_st_addr;
    assign acc_size = ld_grant ? i_ld_size : i_st_size;

    dmem_lane_fmt u_lane_fmt (
        .chk_off        (acc_addr[1:0]),
        .chk_size       (acc_size),
        .chk_misaligned (acc_mis),
        .off            (addr_q[1:0]),
        .size           (size_q),
        .is_unsigned    (uns_q),
        .rd_data        (i_mem_rd_data),
        .ld_data        (fmt_ld_data),
        .st_data        (st_data_q),
        .merged         (fmt_merged)
    );

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        addr_d      = addr_q;
        size_d      = size_q;
        uns_d       = uns_q;
        tag_d       = tag_q;
        st_data_d   = st_data_q;
        ldr_valid_d = 1'b0;
        ldr_data_d  = ldr_data_q;
        ldr_tag_d   = ldr_tag_q;
        ldr_mis_d   = 1'b0;
        st_done_d   = 1'b0;
        st_mis_d    = 1'b0;
        wr_en       = 1'b0;
        wr_data     = fmt_merged;
        mem_word    = addr_q[RV32_ADDR_WIDTH-1:2];
        o_ld_ready  = 1'b0;
        o_st_ready  = 1'b0;

        case (state_q)
            S_IDLE: begin
                o_ld_ready = ld_grant;
                o_st_ready = st_grant;
                if (i_st_valid) begin
                    if (st_grant)     starve_d = '0;
                    else if (!starved) starve_d = starve_q + 1'b1;
                end
                if (ld_grant || st_grant) begin
                    mem_word = acc_addr[RV32_ADDR_WIDTH-1:2];
                    addr_d   = acc_addr;
                    size_d   = acc_size;
                end
                if (ld_grant) begin
                    uns_d = i_ld_unsigned;
                    tag_d = i_ld_tag;
                    if (acc_mis) begin
                        ldr_valid_d = 1'b1;
                        ldr_mis_d   = 1'b1;
                        ldr_data_d  = '0;
                        ldr_tag_d   = i_ld_tag;
                        state_d     = S_RESP_ERR;
                    end else begin
                        state_d = S_LD_WAIT;
                    end
                end else if (st_grant) begin
                    st_data_d = i_st_data;
                    if (acc_mis) begin
                        st_done_d = 1'b1;
                        st_mis_d  = 1'b1;
                        state_d   = S_RESP_ERR;
                    end else if (mem_size_e'(acc_size) == MEM_SIZE_W) begin
                        wr_en     = 1'b1;
                        wr_data   = i_st_data;
                        st_done_d = 1'b1;
                    end else begin
                        state_d = S_ST_MERGE;
                    end
                end
            end
            S_LD_WAIT: begin
                ldr_valid_d = 1'b1;
                ldr_data_d  = fmt_ld_data;
                ldr_tag_d   = tag_q;
                state_d     = S_IDLE;
            end
            S_ST_MERGE: begin
                wr_en     = 1'b1;
                st_done_d = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            starve_q    <= '0;
            addr_q      <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            tag_q       <= '0;
            st_data_q   <= '0;
            ldr_valid_q <= 1'b0;
            ldr_data_q  <= '0;
            ldr_tag_q   <= '0;
            ldr_mis_q   <= 1'b0;
            st_done_q   <= 1'b0;
            st_mis_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            tag_q       <= tag_d;
            st_data_q   <= st_data_d;
            ldr_valid_q <= ldr_valid_d;
            ldr_data_q  <= ldr_data_d;
            ldr_tag_q   <= ldr_tag_d;
            ldr_mis_q   <= ldr_mis_d;
            st_done_q   <= st_done_d;
            st_mis_q    <= st_mis_d;
        end
    end

    assign o_mem_addr       = {2'b00, mem_word};
    assign o_mem_wr_en      = wr_en && !rst;
    assign o_mem_wr_data    = wr_data;
    assign o_ldr_valid      = ldr_valid_q;
    assign o_ldr_data       = ldr_data_q;
    assign o_ldr_tag        = ldr_tag_q;
    assign o_ldr_misaligned = ldr_mis_q;
    assign o_st_done        = st_done_q;
    assign o_st_misaligned  = st_mis_q;

endmodule

// File: tb/tb_dmem_arb_ctrl.sv
// Directed bench for dmem_arb_ctrl with a behavioural synchronous-read memory.
// Inputs are driven and outputs sampled around the falling clock edge.
module tb_dmem_arb_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        preload = 1'b1;
    logic        ld_valid = 1'b0, ld_unsigned = 1'b0;
    logic [31:0] ld_addr = '0;
    logic [1:0]  ld_size = '0;
    logic [3:0]  ld_tag = '0;
    logic        st_valid = 1'b0;
    logic [31:0] st_addr = '0, st_data = '0;
    logic [1:0]  st_size = '0;
    logic        ld_ready, st_ready, ldr_valid, ldr_mis, st_done, st_mis, mem_wr_en;
    logic [31:0] ldr_data, mem_addr, mem_wr_data;
    logic [3:0]  ldr_tag;
    logic [31:0] mem_rd_data;
    logic [31:0] mem [0:63];

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    dmem_arb_ctrl #(.TAG_WIDTH(4), .STARVE_LIMIT(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_ld_valid       (ld_valid),
        .o_ld_ready       (ld_ready),
        .i_ld_addr        (ld_addr),
        .i_ld_size        (ld_size),
        .i_ld_unsigned    (ld_unsigned),
        .i_ld_tag         (ld_tag),
        .o_ldr_valid      (ldr_valid),
        .o_ldr_data       (ldr_data),
        .o_ldr_tag        (ldr_tag),
        .o_ldr_misaligned (ldr_mis),
        .i_st_valid       (st_valid),
        .o_st_ready       (st_ready),
        .i_st_addr        (st_addr),
        .i_st_size        (st_size),
        .i_st_data        (st_data),
        .o_st_done        (st_done),
        .o_st_misaligned  (st_mis),
        .o_mem_addr       (mem_addr),
        .o_mem_wr_en      (mem_wr_en),
        .o_mem_wr_data    (mem_wr_data),
        .i_mem_rd_data    (mem_rd_data)
    );

    always @(posedge clk) begin
        if (preload) begin
            for (int unsigned i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[5] <= 32'h8001_1234;
            mem[9] <= 32'h1122_3344;
        end else if (mem_wr_en) begin
            mem[mem_addr[5:0]] <= mem_wr_data;
        end
        mem_rd_data <= mem[mem_addr[5:0]];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
        end
    endtask

    // Starts and ends on a falling edge with the load inputs idle.
    task automatic do_load(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                           input logic [3:0] tag, input logic [31:0] exp_data, input logic exp_mis);
        int unsigned waited = 0;
        ld_valid = 1'b1; ld_addr = addr; ld_size = size; ld_unsigned = uns; ld_tag = tag;
        #1;
        while (!ld_ready && waited < 20) begin
            @(negedge clk); #1; waited++;
        end
        if (!ld_ready) begin
            check_eq("ld_accept_timeout", 32'd0, 32'd1);
            ld_valid = 1'b0;
            return;
        end
        check_eq("ld_no_write", {31'd0, mem_wr_en}, 32'd0);
        if (!exp_mis) check_eq("ld_mem_addr", mem_addr, addr >> 2);
        @(negedge clk);
        ld_valid = 1'b0;
        if (!exp_mis) begin
            check_eq("ld_wait_no_resp", {31'd0, ldr_valid}, 32'd0);
            @(negedge clk);
        end
        check_eq("ldr_valid", {31'd0, ldr_valid}, 32'd1);
        check_eq("ldr_data", ldr_data, exp_data);
        check_eq("ldr_tag", {28'd0, ldr_tag}, {28'd0, tag});
        check_eq("ldr_mis", {31'd0, ldr_mis}, {31'd0, exp_mis});
        @(negedge clk);
        check_eq("ldr_pulse_end", {31'd0, ldr_valid}, 32'd0);
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] data,
                            input logic exp_mis, input logic [31:0] exp_word);
        int unsigned waited = 0;
        logic sub;
        sub = !exp_mis && (size != 2'b10);
        st_valid = 1'b1; st_addr = addr; st_size = size; st_data = data;
        #1;
        while (!st_ready && waited < 20) begin
            @(negedge clk); #1; waited++;
        end
        if (!st_ready) begin
            check_eq("st_accept_timeout", 32'd0, 32'd1);
            st_valid = 1'b0;
            return;
        end
        if (exp_mis || sub) begin
            check_eq("st_acc_no_write", {31'd0, mem_wr_en}, 32'd0);
        end else begin
            check_eq("st_word_wr_en", {31'd0, mem_wr_en}, 32'd1);
            check_eq("st_word_wr_data", mem_wr_data, exp_word);
            check_eq("st_word_addr", mem_addr, addr >> 2);
        end
        if (sub) check_eq("st_rd_addr", mem_addr, addr >> 2);
        @(negedge clk);
        st_valid = 1'b0;
        if (sub) begin
            ld_valid = 1'b1;
            #1;
            check_eq("merge_no_accept", {31'd0, ld_ready}, 32'd0);
            ld_valid = 1'b0;
            check_eq("merge_wr_en", {31'd0, mem_wr_en}, 32'd1);
            check_eq("merge_wr_data", mem_wr_data, exp_word);
            check_eq("merge_addr", mem_addr, addr >> 2);
            @(negedge clk);
        end
        #1;
        check_eq("st_done", {31'd0, st_done}, 32'd1);
        check_eq("st_mis", {31'd0, st_mis}, {31'd0, exp_mis});
        if (exp_mis) check_eq("st_mis_no_write", {31'd0, mem_wr_en}, 32'd0);
        @(negedge clk);
        check_eq("st_done_pulse_end", {31'd0, st_done}, 32'd0);
    endtask

    int unsigned ld_cnt, st_cnt, ld_before_first, ld_between, first_st_cyc, both_ready;
    int unsigned n_acc, n_resp;
    logic [31:0] exp_q_data [$];
    logic [3:0]  exp_q_tag [$];
    logic [31:0] b2b_addr [5];
    logic [31:0] b2b_data [5];

    initial begin
        repeat (3) @(negedge clk);
        preload = 1'b0;
        check_eq("rst_ldr_valid", {31'd0, ldr_valid}, 32'd0);
        check_eq("rst_ldr_data", ldr_data, 32'd0);
        check_eq("rst_ldr_tag", {28'd0, ldr_tag}, 32'd0);
        check_eq("rst_ldr_mis", {31'd0, ldr_mis}, 32'd0);
        check_eq("rst_st_done", {31'd0, st_done}, 32'd0);
        check_eq("rst_st_mis", {31'd0, st_mis}, 32'd0);
        check_eq("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        do_store(32'h10, 2'b10, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF);
        do_load(32'h10, 2'b10, 1'b0, 4'd3, 32'hDEAD_BEEF, 1'b0);

        do_store(32'h11, 2'b00, 32'hAAAA_AA7F, 1'b0, 32'hDEAD_7FEF);
        check_eq("mem_after_byte_st", mem[4], 32'hDEAD_7FEF);
        do_load(32'h13, 2'b00, 1'b0, 4'd4, 32'hFFFF_FFDE, 1'b0);
        do_load(32'h13, 2'b00, 1'b1, 4'd5, 32'h0000_00DE, 1'b0);
        do_load(32'h10, 2'b00, 1'b0, 4'd6, 32'hFFFF_FFEF, 1'b0);

        do_store(32'h12, 2'b01, 32'h0000_8001, 1'b0, 32'h8001_7FEF);
        do_load(32'h12, 2'b01, 1'b0, 4'd7, 32'hFFFF_8001, 1'b0);
        do_load(32'h10, 2'b01, 1'b1, 4'd8, 32'h0000_7FEF, 1'b0);
        do_load(32'h16, 2'b01, 1'b0, 4'd9, 32'hFFFF_8001, 1'b0);
        do_load(32'h11, 2'b01, 1'b0, 4'd10, 32'h0, 1'b1);
        do_load(32'h10, 2'b11, 1'b0, 4'd2, 32'h0, 1'b1);
        do_store(32'h06, 2'b10, 32'hCAFE_F00D, 1'b1, 32'h0);
        check_eq("mem_after_mis_st", mem[1], 32'h0);
        do_store(32'h13, 2'b01, 32'h0000_5555, 1'b1, 32'h0);
        check_eq("mem_after_mis_half", mem[4], 32'h8001_7FEF);

        // Starvation: both requesters held valid continuously.
        ld_valid = 1'b1; ld_addr = 32'h10; ld_size = 2'b10; ld_unsigned = 1'b0; ld_tag = 4'd1;
        st_valid = 1'b1; st_addr = 32'h20; st_size = 2'b10; st_data = 32'h1234_5678;
        ld_cnt = 0; st_cnt = 0; ld_before_first = 0; ld_between = 0; first_st_cyc = 99; both_ready = 0;
        for (int unsigned c = 0; c < 24; c++) begin
            #1;
            if (ld_ready && st_ready) both_ready++;
            if (ld_ready) ld_cnt++;
            if (st_ready) begin
                st_cnt++;
                if (st_cnt == 1) begin
                    ld_before_first = ld_cnt;
                    first_st_cyc = c;
                end else if (st_cnt == 2) begin
                    ld_between = ld_cnt - ld_before_first;
                end
            end
            @(negedge clk);
        end
        ld_valid = 1'b0; st_valid = 1'b0;
        check_eq("starve_loads_first", ld_before_first, 32'd4);
        check_eq("starve_first_st_cyc", first_st_cyc, 32'd8);
        check_eq("starve_loads_between", ld_between, 32'd4);
        check_eq("starve_store_grants", st_cnt, 32'd2);
        check_eq("starve_both_ready", both_ready, 32'd0);
        repeat (4) @(negedge clk);
        check_eq("mem_after_starve_st", mem[8], 32'h1234_5678);

        // Reset during the merge cycle of a byte RMW.
        st_valid = 1'b1; st_addr = 32'h25; st_size = 2'b00; st_data = 32'h0000_00FF;
        #1;
        check_eq("rmw_rst_accept", {31'd0, st_ready}, 32'd1);
        @(negedge clk);
        st_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("rmw_rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check_eq("rmw_rst_no_done", {31'd0, st_done}, 32'd0);
        check_eq("rmw_rst_mem", mem[9], 32'h1122_3344);
        ld_valid = 1'b1; ld_addr = 32'h24; ld_size = 2'b10; ld_tag = 4'd12;
        #1;
        check_eq("rmw_rst_ready", {31'd0, ld_ready}, 32'd1);
        @(negedge clk);
        ld_valid = 1'b0;
        check_eq("rmw_rst_no_done2", {31'd0, st_done}, 32'd0);
        @(negedge clk);
        check_eq("rmw_rst_ld_valid", {31'd0, ldr_valid}, 32'd1);
        check_eq("rmw_rst_ld_data", ldr_data, 32'h1122_3344);
        @(negedge clk);

        // Back-to-back word loads with valid held high.
        b2b_addr[0] = 32'h10; b2b_data[0] = 32'h8001_7FEF;
        b2b_addr[1] = 32'h14; b2b_data[1] = 32'h8001_1234;
        b2b_addr[2] = 32'h24; b2b_data[2] = 32'h1122_3344;
        b2b_addr[3] = 32'h18; b2b_data[3] = 32'h0000_0000;
        b2b_addr[4] = 32'h20; b2b_data[4] = 32'h1234_5678;
        n_acc = 0; n_resp = 0;
        for (int unsigned c = 0; c < 12; c++) begin
            check_eq("b2b_resp_valid", {31'd0, ldr_valid},
                     {31'd0, (c >= 2 && c <= 10 && (c % 2) == 0)});
            if (ldr_valid) begin
                n_resp++;
                if (exp_q_data.size() == 0) begin
                    check_eq("b2b_unexpected_resp", 32'd1, 32'd0);
                end else begin
                    check_eq("b2b_data", ldr_data, exp_q_data.pop_front());
                    check_eq("b2b_tag", {28'd0, ldr_tag}, {28'd0, exp_q_tag.pop_front()});
                end
            end
            if (c < 10) begin
                ld_valid = 1'b1; ld_size = 2'b10; ld_unsigned = 1'b0;
                ld_addr = b2b_addr[n_acc % 5]; ld_tag = 4'(8 + n_acc);
            end else begin
                ld_valid = 1'b0;
            end
            #1;
            check_eq("b2b_ready", {31'd0, ld_ready}, {31'd0, (c < 10 && (c % 2) == 0)});
            if (ld_ready) begin
                exp_q_data.push_back(b2b_data[n_acc % 5]);
                exp_q_tag.push_back(4'(8 + n_acc));
                n_acc++;
            end
            @(negedge clk);
        end
        check_eq("b2b_resp_count", n_resp, 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dmem_arb_ctrl.md
Name: dmem_arb_ctrl

Overview:
Controller and arbiter in front of the single-port, word-wide, synchronous-read data memory. It serves two requesters: the load pipe and the committed-store drain. Both use valid/ready handshakes. The block performs byte/halfword load extraction with sign/zero extension, read-modify-write for sub-word stores, misalignment detection, and starvation-bounded load-over-store priority.

Parameters:
TAG_WIDTH, 4, width of the load tag returned with the load response.
STARVE_LIMIT, 4, consecutive cycles a valid store may lose arbitration before it is forced to win.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
i_ld_valid  in  1  load request valid
o_ld_ready  out  1  load request accepted this cycle
i_ld_addr  in  RV32_ADDR_WIDTH  load byte address
i_ld_size  in  2  00 byte, 01 half, 10 word, 11 illegal
i_ld_unsigned  in  1  zero-extend when 1, sign-extend when 0
i_ld_tag  in  TAG_WIDTH  load tag
o_ldr_valid  out  1  load response pulse (no backpressure)
o_ldr_data  out  RV32_DATA_WIDTH  extended load data
o_ldr_tag  out  TAG_WIDTH  tag of the responding load
o_ldr_misaligned  out  1  load faulted; data is 0
i_st_valid  in  1  store request valid
o_st_ready  out  1  store request accepted this cycle
i_st_addr  in  RV32_ADDR_WIDTH  store byte address
i_st_size  in  2  same encoding as i_ld_size
i_st_data  in  RV32_DATA_WIDTH  store data, right-aligned
o_st_done  out  1  store completion pulse
o_st_misaligned  out  1  store faulted; memory is untouched
o_mem_addr  out  RV32_ADDR_WIDTH  word index (byte address >> 2)
o_mem_wr_en  out  1  memory write enable
o_mem_wr_data  out  RV32_DATA_WIDTH  memory write data
i_mem_rd_data  in  DMEM_DATA_WIDTH  memory read data, registered one cycle after o_mem_addr

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- On reset:
  - FSM goes to IDLE and the starvation counter clears.
  - o_ldr_valid, o_ldr_misaligned, o_st_done, o_st_misaligned, o_ldr_data and o_ldr_tag are 0.
  - o_mem_wr_en is forced to 0 combinationally whenever rst=1, including mid-operation.
  - An in-flight load or RMW is abandoned: no response is issued and no write occurs.
- FSM states:
  - IDLE: accept and arbitrate.
  - LD_WAIT: read data is arriving.
  - ST_MERGE: RMW write cycle.
  - RESP_ERR: misaligned response cycle.
- Ready signals: o_ld_ready and o_st_ready are asserted only in IDLE. At most one is high per cycle.
- Arbitration in IDLE with both valid:
  - The load wins unless the starvation counter equals STARVE_LIMIT; in that case the store wins.
  - The counter increments (saturating) each cycle i_st_valid=1 and the store is not granted.
  - The counter clears on store grant.
- Memory address: o_mem_addr is combinational from the granted request in the acceptance cycle, and from the latched address in all other states. This keeps the read address stable for the synchronous memory.
- Misalignment rules:
  - half with addr[0]=1 is misaligned.
  - word with addr[1:0]!=0 is misaligned.
  - size 11 is misaligned.
  - A misaligned request is accepted, never touches memory (wr_en=0), and goes to RESP_ERR.
  - In the next cycle: a load gets o_ldr_valid=1, o_ldr_misaligned=1, data=0, and its tag; a store gets o_st_done=1 and o_st_misaligned=1.
- Load, accepted at cycle T:
  - T+1 in LD_WAIT: the byte lane is selected by addr[1:0] (half lane by addr[1]) and extended.
  - Result is registered and presented at T+2 as o_ldr_valid=1 for one cycle with the tag. Load-to-response latency is 2 cycles.
  - The FSM returns to IDLE at T+2, so a new accept is possible at T+2.
- Word store, accepted at T: o_mem_wr_en=1 with wr_data=i_st_data in T. o_st_done pulses at T+1. Single-cycle occupancy.
- Sub-word store, accepted at T:
  - T: read issued with wr_en=0.
  - T+1 (ST_MERGE): i_mem_rd_data is merged with the new byte/half in the addressed lane, and written with wr_en=1.
  - o_st_done pulses at T+2.
  - The RMW is atomic: no request is accepted during ST_MERGE.
- Store-then-load ordering: a load accepted after store completion observes the stored value. Memory write-then-read ordering guarantees this.
- Pulse outputs are registered and high for exactly one cycle.

Decomposition:
- Shared constants go in constants.vh:
  - MEM_SIZE_B/H/W/ILL encodings (2'b00..2'b11).
  - LDST_TAG_WIDTH default.
  - Existing RV32_ADDR_WIDTH, RV32_DATA_WIDTH and DMEM_DATA_WIDTH are reused.
- One combinational sub-module, dmem_lane_fmt:
  - load extract/extend (rd_data, offset, size, unsigned → data).
  - store merge (old word, new data, offset, size → merged word).
  - misalignment check.
- The FSM, arbitration counter and response registers stay in dmem_arb_ctrl.

Test Plan:
- Word store 0xDEADBEEF @0x10, then word load @0x10 tag 3 → wr_en=1, o_mem_addr=4 in accept cycle; o_st_done next cycle; o_ldr_valid 2 cycles after load accept, data 0xDEADBEEF, tag 3.
- Byte store 0x7F @0x11 over word 0xDEADBEEF → read then write cycle, memory becomes 0xDEAD7FEF; o_st_done at T+2. Then load byte signed @0x13 → 0xFFFFFFDE; unsigned → 0x000000DE.
- Half load signed @0x12 of 0x8001xxxx → 0xFFFF8001; half load @0x11 → o_ldr_misaligned=1, data 0, no memory access. Word store @0x06 → o_st_misaligned=1, memory unchanged.
- Load and store both valid continuously, STARVE_LIMIT=4 → loads granted 4 times, store granted on the 5th arbitration; the counter then restarts.
- rst asserted in the ST_MERGE cycle → o_mem_wr_en=0, no o_st_done, memory word unchanged; FSM in IDLE and ready next cycle.
- Back-to-back loads with i_ld_valid held high → o_ld_ready high every second cycle; responses in order with matching tags.
